// File: rtl/uart_wb_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone bridge.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/uart_wb_master_if.sv
// Wishbone initiator bus between uart_wb_master and the user-area slaves.
interface uart_wb_master_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/uart_wb_master.sv
// UART command-frame parser issuing single 32-bit Wishbone cycles and returning response bytes.
// Optional bus timeout (RSP_ERR response) enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_master
  import uart_wb_pkg::*;
`ifdef UART_WB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  uart_wb_master_if.master  wb,
  output logic              overrun
);

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic        we;
  logic        err;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] rd_data;
  logic        bus_act;
  logic        tmo_hit;
  logic        is_cmd;
  logic        resp_last;

  assign is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign resp_last = err || we || (byte_cnt == 2'd3);

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != BUS) tmo_cnt <= '0;
    else if (!wb.wbm_ack_i)     tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Fires during the last allowed BUS cycle; an ack in that same cycle still wins.
  assign tmo_hit = (state == BUS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_valid && is_cmd)              state_nx = ADDR;
      ADDR: if (rx_valid && byte_cnt == 2'd3)    state_nx = we ? DATA : BUS;
      DATA: if (rx_valid && byte_cnt == 2'd3)    state_nx = BUS;
      BUS:  if (wb.wbm_ack_i || tmo_hit)         state_nx = RESP;
      RESP: if (tx_ready && resp_last)           state_nx = IDLE;
      default:                                   state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus_act  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      BUS:  bus_act = 1'b1;
      RESP: begin
        tx_valid = 1'b1;
        if (err)     tx_data = RSP_ERR;
        else if (we) tx_data = RSP_OK;
        else begin
          case (byte_cnt)
            2'd0:    tx_data = rd_data[31:24];
            2'd1:    tx_data = rd_data[23:16];
            2'd2:    tx_data = rd_data[15:8];
            default: tx_data = rd_data[7:0];
          endcase
        end
      end
      default: ;
    endcase
  end

  assign wb.wbm_cyc_o = bus_act;
  assign wb.wbm_stb_o = bus_act;
  assign wb.wbm_sel_o = {4{bus_act}};
  assign wb.wbm_we_o  = we;
  assign wb.wbm_adr_o = adr;
  assign wb.wbm_dat_o = dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      we       <= 1'b0;
      err      <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      rd_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= rx_valid && (state == BUS || state == RESP);
      case (state)
        IDLE: if (rx_valid && is_cmd) begin
          we       <= (rx_data == CMD_WRITE);
          err      <= 1'b0;
          byte_cnt <= '0;
        end
        ADDR: if (rx_valid) begin
          adr      <= {adr[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        DATA: if (rx_valid) begin
          dat      <= {dat[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        BUS: begin
          if (wb.wbm_ack_i) begin
            if (!we) rd_data <= wb.wbm_dat_i;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end
        end
        RESP: if (tx_ready) byte_cnt <= byte_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_wb_master;

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TMO_N = 16;
`else
  localparam int unsigned TMO_N = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_wb_master_if wb();

`ifdef UART_WB_TIMEOUT_EN
  uart_wb_master #(.TIMEOUT_CYCLES(16)) dut (
`else
  uart_wb_master dut (
`endif
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb       (wb.master),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // One full frame: ack arrives in BUS cycle ack_d+1; ov_c>0 injects a stray rx byte in that BUS cycle.
  task automatic run_txn(input bit is_w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rv, input int unsigned ack_d,
                         input int unsigned ov_c, input bit gaps);
    logic [7:0]  exp_q[$];
    int unsigned n_ack;
    int unsigned cycles;
    bit          exp_err;
    send_byte(is_w ? 8'h57 : 8'h52, gaps);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], gaps);
    if (is_w) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], gaps);
    chk("cyc_latency", {31'd0, wb.wbm_cyc_o}, 32'd1);
    chk("stb", {31'd0, wb.wbm_stb_o}, 32'd1);
    chk("sel", {28'd0, wb.wbm_sel_o}, 32'hF);
    chk("we", {31'd0, wb.wbm_we_o}, {31'd0, is_w});
    chk("adr", wb.wbm_adr_o, a);
    if (is_w) chk("dat_o", wb.wbm_dat_o, d);
    n_ack   = ack_d + 1;
    exp_err = (TMO_N != 0) && (n_ack > TMO_N);
    cycles  = exp_err ? TMO_N : n_ack;
    for (int unsigned c = 1; c <= cycles; c++) begin
      chk("cyc_held", {31'd0, wb.wbm_cyc_o}, 32'd1);
      wb.wbm_ack_i = (c == n_ack);
      wb.wbm_dat_i = (c == n_ack) ? rv : $urandom();
      if (c == ov_c) begin
        rx_data  = 8'($urandom());
        rx_valid = 1'b1;
      end
      tick();
      rx_valid     = 1'b0;
      wb.wbm_ack_i = 1'b0;
      chk("overrun", {31'd0, overrun}, {31'd0, (c == ov_c)});
    end
    chk("cyc_drop", {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("stb_drop", {31'd0, wb.wbm_stb_o}, 32'd0);
    if (exp_err)   exp_q = '{8'h45};
    else if (is_w) exp_q = '{8'h4B};
    else           exp_q = '{rv[31:24], rv[23:16], rv[15:8], rv[7:0]};
    for (int i = 0; i < exp_q.size(); i++) begin
      int unsigned st = $urandom_range(0, 3);
      repeat (st) begin
        chk("tx_valid_stall", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_stall", {24'd0, tx_data}, {24'd0, exp_q[i]});
        tick();
      end
      chk("tx_valid", {31'd0, tx_valid}, 32'd1);
      chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q[i]});
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("tx_idle", {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = '0;

    repeat (3) tick();
    chk("rst_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb.wbm_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb.wbm_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wb.wbm_sel_o}, 32'd0);
    chk("rst_adr", wb.wbm_adr_o, 32'd0);
    chk("rst_dat", wb.wbm_dat_o, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 32'd0, 1, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0008, 32'd0, 32'h1234_5678, $urandom_range(0, 3), 0, 1'b0);

    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h41, 1'b0);
    for (int i = 0; i < 4; i++) begin
      g = 8'($urandom());
      if (g == 8'h57 || g == 8'h52) g = 8'h00;
      send_byte(g, 1'b1);
    end
    chk("garbage_idle", {31'd0, wb.wbm_cyc_o}, 32'd0);
    run_txn(1'b0, 32'h3000_0000, 32'd0, $urandom(), 2, 0, 1'b0);

    run_txn(1'b1, $urandom(), $urandom(), 32'd0, 4, 2, 1'b1);
    run_txn(1'b0, $urandom(), 32'd0, $urandom(), 3, 4, 1'b0);

    send_byte(8'h52, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0);
    chk("midbus_cyc", {31'd0, wb.wbm_cyc_o}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("midrst_stb", {31'd0, wb.wbm_stb_o}, 32'd0);
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_cyc", {31'd0, wb.wbm_cyc_o}, 32'd0);
    chk("postrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    run_txn(1'b1, $urandom(), $urandom(), 32'd0, 0, 0, 1'b0);

    run_txn(1'b0, $urandom(), 32'd0, $urandom(), 15, 0, 1'b0);
    run_txn(1'b0, $urandom(), 32'd0, $urandom(), 40, 0, 1'b0);
    run_txn(1'b1, $urandom(), $urandom(), 32'd0, 30, 0, 1'b0);
    run_txn(1'b0, $urandom(), 32'd0, $urandom(), 16, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
              $urandom_range(0, 20), $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
